// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage with PC, instruction register, redirect squash and sticky fault
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 64
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic [31:0] oInstAddr,
  input  logic [31:0] iInstData,
  output logic [31:0] oInst,
  output logic [31:0] oInstPc,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oFault,
  output logic [31:0] oFetchCnt
);
  localparam logic [31:0] PC_MASK = 32'(ROM_DEPTH * 4 - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  typedef enum logic {RUN, FAULT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        fire, load, illegal;
  assign fire    = valid_q & iReady;
  assign load    = !valid_q | iReady;
  assign illegal = (iRedirectPc[1:0] != 2'b00) || ({2'b00, iRedirectPc[31:2]} >= 32'(ROM_DEPTH));
  assign oInstAddr = pc_q;
  assign oInst     = inst_q;
  assign oInstPc   = inst_pc_q;
  assign oValid    = valid_q;
  assign oFault    = state_q == FAULT;
  assign oFetchCnt = cnt_q;
  // next-state: redirect beats load beats stall; FAULT freezes everything but drops valid
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (state_q == RUN) begin
      cnt_d = fire ? cnt_q + 32'd1 : cnt_q;
      if (iRedirect && illegal) begin
        state_d = FAULT;
        valid_d = 1'b0;
      end else if (iRedirect) begin
        pc_d    = iRedirectPc;
        valid_d = 1'b0;
      end else if (load) begin
        inst_d    = iInstData;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
        pc_d      = (pc_q + 32'd4) & PC_MASK;
      end
    end else begin
      valid_d = 1'b0;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      inst_pc_q <= 32'd0;
      valid_q   <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a behavioural ROM
module tb_inst_fetch;
  logic        iClk, iRst, oValid, iReady, iRedirect, oFault;
  logic [31:0] oInstAddr, iInstData, oInst, oInstPc, iRedirectPc, oFetchCnt;
  logic [31:0] rom [64];
  logic [31:0] exp_q [$];
  int          n_vec = 0, n_err = 0;
  inst_fetch #(.RESET_PC(32'h0), .ROM_DEPTH(64)) dut (
    .iClk(iClk), .iRst(iRst), .oInstAddr(oInstAddr), .iInstData(iInstData),
    .oInst(oInst), .oInstPc(oInstPc), .oValid(oValid), .iReady(iReady),
    .iRedirect(iRedirect), .iRedirectPc(iRedirectPc), .oFault(oFault), .oFetchCnt(oFetchCnt)
  );
  assign iInstData = rom[oInstAddr[7:2]];
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] e;
    if (oValid === 1'b1 && iReady === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_fire", oInstPc, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("sb_pc", oInstPc, e);
        chk("sb_inst", oInst, rom[e[7:2]]);
      end
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask
  task automatic chk_reset();
    chk("rst_addr", oInstAddr, 32'h0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_inst", oInst, 32'h13);
    chk("rst_pc", oInstPc, 32'h0);
    chk("rst_cnt", oFetchCnt, 32'd0);
    chk("rst_fault", 32'(oFault), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 | (i << 8) | (i ^ 8'h5A);
    iRst = 1'b1; iReady = 1'b0; iRedirect = 1'b0; iRedirectPc = 32'h0;
    tick(); tick();
    chk_reset();
    iRst = 1'b0; iReady = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    tick(); tick(); tick();
    chk("run_pc8", oInstPc, 32'h8);
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inst", oInst, rom[2]);
      chk("stall_pc", oInstPc, 32'h8);
      chk("stall_addr", oInstAddr, 32'hC);
      chk("stall_cnt", oFetchCnt, 32'd2);
      chk("stall_valid", 32'(oValid), 32'd1);
    end
    iReady = 1'b1;
    tick();
    chk("release_pc", oInstPc, 32'hC);
    for (int i = 3; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 7; i++) tick();
    chk("free_cnt10", oFetchCnt, 32'd10);
    iReady = 1'b0; iRedirect = 1'b1; iRedirectPc = 32'h20;
    tick();
    iRedirect = 1'b0;
    chk("redir_valid", 32'(oValid), 32'd0);
    chk("redir_addr", oInstAddr, 32'h20);
    tick();
    chk("redir_inst", oInst, rom[8]);
    chk("redir_pc", oInstPc, 32'h20);
    chk("redir_valid1", 32'(oValid), 32'd1);
    chk("redir_cnt", oFetchCnt, 32'd10);
    iRedirect = 1'b1; iRedirectPc = 32'hFC;
    tick();
    iRedirect = 1'b0; iReady = 1'b1;
    exp_q.push_back(32'hFC); exp_q.push_back(32'h0);
    tick();
    chk("wrap_pc", oInstPc, 32'hFC);
    chk("wrap_addr", oInstAddr, 32'h0);
    tick();
    chk("wrap_pc0", oInstPc, 32'h0);
    chk("wrap_inst0", oInst, rom[0]);
    chk("wrap_fault", 32'(oFault), 32'd0);
    tick();
    iReady = 1'b0;
    chk("wrap_cnt", oFetchCnt, 32'd12);
    iRedirect = 1'b1; iRedirectPc = 32'h22;
    tick();
    iReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iRedirect = i[0]; iRedirectPc = 32'h10;
      chk("flt_fault", 32'(oFault), 32'd1);
      chk("flt_valid", 32'(oValid), 32'd0);
      chk("flt_cnt", oFetchCnt, 32'd12);
      tick();
    end
    iRedirect = 1'b0; iRst = 1'b1;
    tick();
    iRst = 1'b0; iReady = 1'b0;
    chk_reset();
    tick();
    chk("pre_big_valid", 32'(oValid), 32'd1);
    iRedirect = 1'b1; iRedirectPc = 32'h100;
    tick();
    iRedirect = 1'b0; iReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("big_fault", 32'(oFault), 32'd1);
      chk("big_valid", 32'(oValid), 32'd0);
      tick();
    end
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) tick();
    iReady = 1'b0;
    tick();
    chk("mid_cnt5", oFetchCnt, 32'd5);
    chk("mid_valid", 32'(oValid), 32'd1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk_reset();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
